// File: rtl/axi_modport_slave.sv
// -----------------------------------------------------------------------------
// axi_modport_slave
//
// AXI3-style memory-mapped slave with independent write (AW/W/B) and read
// (AR/R) engines sharing one word-addressed memory of MEM_DEPTH x 32 bits.
// One outstanding transaction per direction; IDs are echoed back unchanged.
//
// Optional build macro:
//   AXI_SLV_RANGE_CHECK_EN - beats whose byte address is >= MEM_DEPTH*4 do not
//                            touch memory; the write burst answers SLVERR, and
//                            the read beat returns RDATA=0 with RRESP=SLVERR.
//                            Without the macro, addresses alias modulo the
//                            memory size and every response is OKAY.
//
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST/VALID -> READY)    write address channel
//   W*   (ID/DATA/STRB/LAST/VALID -> READY)         write data channel (WID ignored)
//   B*   (ID/RESP/VALID <- READY)                   write response channel
//   AR*  (ID/ADDR/LEN/SIZE/BURST/VALID -> READY)    read address channel
//   R*   (ID/DATA/RESP/LAST/VALID <- READY)         read data channel
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both 1. A source holds VALID and its payload
// stable until that edge; READY may change freely while VALID is low.
// -----------------------------------------------------------------------------
module axi_modport_slave #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // write address
  input  logic [3:0]        AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [3:0]        WID,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [3:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address
  input  logic [3:0]        ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [3:0]        RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // *_INIT is the state held during reset: it keeps both READYs low while
  // ARESET is high and releases them one cycle after reset drops.
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA}         r_state_e;

  // WID carries no information for a single-outstanding slave.
  logic unused_wid;
  assign unused_wid = ^WID;

  // ---------------------------------------------------------------------------
  // Shared helpers
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd2) ? 3'd2 : size;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[2 +: IDX_W];
  endfunction

  // Address of the beat following 'addr'. WRAP keeps the low bits inside an
  // aligned window of (len+1)<<size bytes; reserved burst type 11 acts as INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [3:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    incr = addr + (ADDR_W'(1) << size);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = incr;
    endcase
  endfunction

`ifdef AXI_SLV_RANGE_CHECK_EN
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:2+IDX_W] == '0);
  endfunction
`endif

  logic [31:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_e          w_state_q, w_state_d;
  logic [3:0]        aw_id_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [3:0]        aw_len_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic [3:0]        w_cnt_q;
  logic              w_err_q;

  logic aw_fire, w_fire, b_fire, w_last_beat, w_beat_ok, w_mem_we;

  assign aw_fire     = AWVALID && (w_state_q == W_IDLE);
  assign w_fire      = WVALID  && (w_state_q == W_DATA);
  assign b_fire      = BREADY  && (w_state_q == W_RESP);
  // An early WLAST closes the burst; so does reaching LEN+1 beats even if the
  // master never raises WLAST, so extra beats are never taken.
  assign w_last_beat = WLAST || (w_cnt_q == aw_len_q);
  assign w_mem_we    = w_fire && w_beat_ok && !ARESET;

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign w_beat_ok = in_range(w_addr_q);
`else
  assign w_beat_ok = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) w_state_q <= W_INIT;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_INIT: w_state_d = W_IDLE;
      W_IDLE: if (aw_fire) w_state_d = W_DATA;
      W_DATA: if (w_fire && w_last_beat) w_state_d = W_RESP;
      W_RESP: if (b_fire) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (w_state_q == W_IDLE);
    WREADY  = (w_state_q == W_DATA);
    BVALID  = (w_state_q == W_RESP);
    BID     = '0;
    BRESP   = RESP_OKAY;
    if (w_state_q == W_RESP) begin
      BID   = aw_id_q;
      BRESP = w_err_q ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_id_q    <= '0;
      w_addr_q   <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else if (aw_fire) begin
      aw_id_q    <= AWID;
      w_addr_q   <= AWADDR;
      aw_len_q   <= AWLEN;
      aw_size_q  <= clamp_size(AWSIZE);
      aw_burst_q <= AWBURST;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else if (w_fire) begin
      w_addr_q <= next_addr(w_addr_q, aw_len_q, aw_size_q, aw_burst_q);
      w_cnt_q  <= w_cnt_q + 4'd1;
      if (!w_beat_ok) w_err_q <= 1'b1;
    end
  end

  // Memory is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_e          r_state_q, r_state_d;
  logic [3:0]        ar_id_q;
  logic [ADDR_W-1:0] r_addr_q;     // address of the beat that will load next
  logic [3:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic [3:0]        r_cnt_q;      // index of the beat currently presented
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  logic              ar_fire, r_fire, r_load, r_ld_ok;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [3:0]        r_ld_len;
  logic [2:0]        r_ld_size;
  logic [1:0]        r_ld_burst;

  assign ar_fire = ARVALID && (r_state_q == R_IDLE);
  assign r_fire  = RREADY  && (r_state_q == R_DATA);
  // A beat is loaded on the AR handshake and on every accepted non-final beat,
  // which gives back-to-back beats with no bubble.
  assign r_load  = ar_fire || (r_fire && !rlast_q);

  // The first beat uses the live AR fields, later beats the latched ones.
  always_comb begin
    r_ld_addr  = r_addr_q;
    r_ld_len   = ar_len_q;
    r_ld_size  = ar_size_q;
    r_ld_burst = ar_burst_q;
    if (ar_fire) begin
      r_ld_addr  = ARADDR;
      r_ld_len   = ARLEN;
      r_ld_size  = clamp_size(ARSIZE);
      r_ld_burst = ARBURST;
    end
  end

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign r_ld_ok = in_range(r_ld_addr);
`else
  assign r_ld_ok = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state_q <= R_INIT;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_INIT: r_state_d = R_IDLE;
      R_IDLE: if (ar_fire) r_state_d = R_DATA;
      R_DATA: if (r_fire && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (r_state_q == R_IDLE);
    RVALID  = (r_state_q == R_DATA);
    RID     = '0;
    RDATA   = '0;
    RRESP   = RESP_OKAY;
    RLAST   = 1'b0;
    if (r_state_q == R_DATA) begin
      RID   = ar_id_q;
      RDATA = rdata_q;
      RRESP = rresp_q;
      RLAST = rlast_q;
    end
  end

  // Memory is sampled at load time, so a write landing on the same edge is
  // not visible to the beat being loaded.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_id_q    <= '0;
      r_addr_q   <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      if (ar_fire) begin
        ar_id_q    <= ARID;
        ar_len_q   <= ARLEN;
        ar_size_q  <= clamp_size(ARSIZE);
        ar_burst_q <= ARBURST;
      end
      if (r_load) begin
        rdata_q  <= r_ld_ok ? mem_q[word_idx(r_ld_addr)] : 32'h0;
        rresp_q  <= r_ld_ok ? RESP_OKAY : RESP_SLVERR;
        r_addr_q <= next_addr(r_ld_addr, r_ld_len, r_ld_size, r_ld_burst);
        r_cnt_q  <= ar_fire ? 4'd0 : r_cnt_q + 4'd1;
        rlast_q  <= ar_fire ? (ARLEN == 4'd0) : ((r_cnt_q + 4'd1) == ar_len_q);
      end else if (r_fire) begin
        rlast_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_modport_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_modport_slave
//
// Directed bench for axi_modport_slave. Master-side tasks drive AW/W/B and
// AR/R; expected read data is queued in exp_q by the stimulus and popped by
// the read task. Inputs change and outputs are sampled 1 time unit after the
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_axi_modport_slave;

  localparam int TMO = 20;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_modport_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wbuf[16];
  logic [3:0]  sbuf[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left 1 unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int nbeats, input int bdelay);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    BREADY  = 1'b0;
    n = 0;
    while (AWREADY !== 1'b1 && n < TMO) begin tick(); n++; end
    check("awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WDATA  = wbuf[i];
      WSTRB  = sbuf[i];
      WLAST  = (i == nbeats - 1);
      WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < TMO) begin tick(); n++; end
      check("wready", WREADY, 1);
      tick();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    // one cycle after the final W handshake
    check("bvalid_lat", BVALID, 1);
    check("bid", BID, id);
    check("bresp", BRESP, 0);
    check("wready_off", WREADY, 0);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", BID, id);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_done", BVALID, 0);
    check("awready_back", AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n;
    logic [31:0] e;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < TMO) begin tick(); n++; end
    check("arready", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (RVALID !== 1'b1 && n < TMO) begin tick(); n++; end
      check("rvalid", RVALID, 1);
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'(exp_q.size()), 1);
        e = 32'h0;
      end else begin
        e = exp_q.pop_front();
      end
      check("rdata", RDATA, e);
      check("rlast", RLAST, (i == int'(len)));
      check("rid", RID, id);
      check("rresp", RRESP, 0);
      tick();
    end
    RREADY = 1'b0;
    check("rvalid_done", RVALID, 0);
    check("arready_back", ARREADY, 1);
  endtask

  task automatic fill_strb();
    for (int i = 0; i < 16; i++) sbuf[i] = 4'hF;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    fill_strb();

    // reset state
    repeat (3) tick();
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_bid", BID, 0);
    ARESET = 1'b0;
    tick();
    check("rel_awready", AWREADY, 1);
    check("rel_arready", ARREADY, 1);

    // single beat write then read
    wbuf[0] = 32'hDEADBEEF;
    do_write(4'h5, 32'h10, 4'd0, 3'd2, INCR, 1, 0);
    exp_q.push_back(32'hDEADBEEF);
    do_read(4'h3, 32'h10, 4'd0, 3'd2, INCR);

    // 4-beat INCR at 0x0
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(4'hA, 32'h0, 4'd3, 3'd2, INCR, 4, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    do_read(4'hB, 32'h0, 4'd3, 3'd2, INCR);

    // byte strobes
    wbuf[0] = 32'hAABBCCDD;
    do_write(4'h1, 32'h20, 4'd0, 3'd2, INCR, 1, 0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
    do_write(4'h2, 32'h20, 4'd0, 3'd2, INCR, 1, 0);
    fill_strb();
    exp_q.push_back(32'hAA22CC44);
    do_read(4'h4, 32'h20, 4'd0, 3'd2, INCR);

    // WRAP: 0x38 -> 0x3C -> 0x30 -> 0x34
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    do_write(4'h6, 32'h38, 4'd3, 3'd2, WRAP, 4, 0);
    exp_q.push_back(32'hC); exp_q.push_back(32'hD);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    do_read(4'h6, 32'h30, 4'd3, 3'd2, INCR);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    exp_q.push_back(32'hC); exp_q.push_back(32'hD);
    do_read(4'h7, 32'h38, 4'd3, 3'd2, WRAP);

    // FIXED: word holds last beat
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(4'h8, 32'h40, 4'd3, 3'd2, FIXED, 4, 0);
    exp_q.push_back(32'h44);
    do_read(4'h8, 32'h40, 4'd0, 3'd2, INCR);

    // early WLAST: AWLEN=3 but burst closes after 2 beats
    wbuf[0] = 32'h7; wbuf[1] = 32'h8;
    do_write(4'h9, 32'h80, 4'd3, 3'd2, INCR, 2, 0);
    exp_q.push_back(32'h7); exp_q.push_back(32'h8);
    do_read(4'h9, 32'h80, 4'd1, 3'd2, INCR);

    // AWSIZE=3 is clamped to 4-byte steps
    wbuf[0] = 32'h90909090; wbuf[1] = 32'h94949494;
    do_write(4'hC, 32'h90, 4'd1, 3'd3, INCR, 2, 0);
    exp_q.push_back(32'h90909090); exp_q.push_back(32'h94949494);
    do_read(4'hC, 32'h90, 4'd1, 3'd2, INCR);

    // read backpressure: RREADY low 3 cycles on beat 1 of 2
    ARID = 4'hD; ARADDR = 32'h0; ARLEN = 4'd1; ARSIZE = 3'd2; ARBURST = INCR;
    ARVALID = 1'b1; RREADY = 1'b0;
    check("bp_arready", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    check("bp_rvalid", RVALID, 1);
    check("bp_rdata0", RDATA, 32'h1);
    check("bp_rlast0", RLAST, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rvalid_hold", RVALID, 1);
      check("bp_rdata_hold", RDATA, 32'h1);
      check("bp_rlast_hold", RLAST, 0);
      check("bp_rid_hold", RID, 4'hD);
    end
    RREADY = 1'b1;
    tick();
    check("bp_rdata1", RDATA, 32'h2);
    check("bp_rlast1", RLAST, 1);
    tick();
    RREADY = 1'b0;
    check("bp_rvalid_done", RVALID, 0);

    // write response backpressure: BREADY low 2 cycles
    wbuf[0] = 32'h0BADF00D;
    do_write(4'hE, 32'h50, 4'd0, 3'd2, INCR, 1, 2);
    exp_q.push_back(32'h0BADF00D);
    do_read(4'hE, 32'h50, 4'd0, 3'd2, INCR);

    // reset in the middle of a 4-beat write
    AWID = 4'h2; AWADDR = 32'h60; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = INCR;
    AWVALID = 1'b1;
    check("mr_awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'h100 + 32'(i);
      check("mr_wready", WREADY, 1);
      tick();
    end
    WDATA = 32'h102;
    ARESET = 1'b1;
    tick();
    check("mr_awready0", AWREADY, 0);
    check("mr_wready0", WREADY, 0);
    check("mr_bvalid0", BVALID, 0);
    check("mr_arready0", ARREADY, 0);
    check("mr_rvalid0", RVALID, 0);
    check("mr_bid0", BID, 0);
    ARESET = 1'b0;
    WVALID = 1'b0;
    tick();
    check("mr_awready1", AWREADY, 1);
    check("mr_arready1", ARREADY, 1);
    wbuf[0] = 32'hCAFEF00D;
    do_write(4'h3, 32'h60, 4'd0, 3'd2, INCR, 1, 0);
    exp_q.push_back(32'hCAFEF00D);
    do_read(4'h3, 32'h60, 4'd0, 3'd2, INCR);

    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_modport_slave.md
Name: axi_modport_slave

Overview:
- AXI3-style memory-mapped slave: 32-bit address and data, 4-bit IDs, bursts of up to 16 beats.
- Implements all five channels (AW, W, B, AR, R) with independent write and read engines over one internal word memory.
- Sits on the slave side of the bus interface and is the endpoint that master-side drivers and monitors exercise.

Parameters:
- MEM_DEPTH, 1024: number of 32-bit words in the memory (power of two).
- ADDR_W, 32: address width.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWID  in  4  write address ID.
- AWADDR  in  32  write start byte address.
- AWLEN  in  4  write beats minus 1.
- AWSIZE  in  3  bytes per beat, log2.
- AWBURST  in  2  write burst type.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WID  in  4  write data ID; ignored.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WLAST  in  1  last write beat.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BID  out  4  response ID.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARID  in  4  read address ID.
- ARADDR  in  32  read start byte address.
- ARLEN  in  4  read beats minus 1.
- ARSIZE  in  3  read size, log2.
- ARBURST  in  2  read burst type.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RID  out  4  read ID.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Reset: all outputs 0; both engines go to IDLE; any burst in flight is aborted. Memory contents are not reset.
- AWREADY and ARREADY go to 1 in the first cycle after ARESET deasserts.
- Word index: addr[2 +: log2(MEM_DEPTH)]; upper bits ignored (aliasing).
- Size clamp: AxSIZE > 2 is treated as 2.
- Address step per beat:
  - FIXED (00): address unchanged.
  - INCR (01): address += 1<<SIZE.
  - WRAP (10): INCR, wrapped within an aligned window of (LEN+1)<<SIZE bytes.
  - 11: treated as INCR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch ID/ADDR/LEN/SIZE/BURST; next cycle AWREADY=0, WREADY=1.
  - W_DATA: each WVALID&&WREADY writes the WDATA bytes enabled by WSTRB to the current word, then advances the address.
  - Burst ends on the beat where WLAST=1 or beat count reaches LEN+1, whichever comes first; extra beats are never accepted.
  - W_RESP: WREADY=0, BVALID=1, BID=latched AWID, BRESP=00 (OKAY). Held stable until BREADY.
  - BVALID&&BREADY returns to W_IDLE; AWREADY=1 the next cycle.
  - Minimum write latency: one-beat write gives BVALID 1 cycle after the W handshake.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch fields; next cycle ARREADY=0, RVALID=1, RDATA=mem[start word], RID=ARID, RRESP=00.
  - RLAST=1 only on beat LEN+1.
  - While RVALID&&!RREADY, RDATA/RID/RRESP/RLAST are held stable.
  - Each RVALID&&RREADY presents the next beat in the following cycle, with no bubble.
  - After the last beat, RVALID=0 and R_IDLE with ARREADY=1.
- Read and write engines run concurrently and independently.
- Same-cycle write handshake and read data capture to the same word: read returns the old value. Read data is sampled from memory when the beat is loaded.
- Only one outstanding transaction per direction; no reordering. IDs are simply echoed.

Optional Feature:
- Macro: AXI_SLV_RANGE_CHECK_EN.
- Defined: a beat whose byte address is >= MEM_DEPTH*4 does not access memory.
  - Write: burst response BRESP=10 (SLVERR) if any beat was out of range.
  - Read: that beat gets RRESP=10 and RDATA=0.
- Undefined: addresses alias modulo the memory size and responses are always OKAY.

Test Plan:
- Reset, then single write: AWADDR=0x10, AWLEN=0, AWSIZE=2, INCR, WDATA=0xDEADBEEF, WSTRB=F, BREADY=1 -> BVALID 1 cycle after W handshake, BRESP=0, BID=AWID. Read of 0x10 -> RDATA=0xDEADBEEF, RLAST=1.
- INCR write at 0x0, AWLEN=3, data 1,2,3,4 -> read back ARLEN=3 gives 1,2,3,4 with RLAST only on the 4th beat.
- Byte strobes: write 0xAABBCCDD WSTRB=F to 0x20, then 0x11223344 WSTRB=0101b -> read 0x20 = 0xAA22CC44.
- WRAP burst: AWADDR=0x38, AWLEN=3, SIZE=2, data A,B,C,D -> words at 0x38,0x3C,0x30,0x34 hold A,B,C,D. FIXED burst of 4 beats to 0x40 -> word holds last beat.
- Backpressure: read burst ARLEN=1 with RREADY low 3 cycles -> RDATA/RLAST stable and no beat skipped. BREADY low 2 cycles -> BVALID held with unchanged BID.
- ARESET asserted mid write burst (after 2 of 4 beats) -> next cycle all outputs 0. After release, AWREADY=ARREADY=1 and a new transaction completes normally.
